// File: rtl/remote_responder.sv
// rtl/remote_responder.sv - remote-access target: round-robin arbiter into a shared SRAM plus a read-only core ID register
// A single access is in flight at a time; requests that drop before ACK abort cleanly.
module remote_responder #(
    parameter int NUM_CORES   = 4,
    parameter int MEM_SIZE    = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [16*NUM_CORES-1:0]   remote_addr,
    input  logic [NUM_CORES-1:0]      remote_wren,
    input  logic [NUM_CORES-1:0]      remote_rden,
    input  logic [16*NUM_CORES-1:0]   remote_write_val,
    output logic [NUM_CORES-1:0]      remote_ready,
    output logic [16*NUM_CORES-1:0]   remote_read_val
);
    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int AW = $clog2(MEM_SIZE);
    localparam logic [GW-1:0] LAST_RST = GW'(NUM_CORES - 1);
    localparam logic [3:0]    WS_LAST  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic [3:0]      cnt_q, cnt_d;

    logic [15:0]     addr_arr [NUM_CORES];
    logic [15:0]     wdata_arr [NUM_CORES];
    logic [15:0]     rv_q [NUM_CORES];
    logic [15:0]     mem [MEM_SIZE];
    logic [15:0]     sram_q;

    logic [NUM_CORES-1:0] req;
    logic [GW-1:0]   pick;
    logic [GW:0]     idx;
    logic            found;
    logic            live;
    logic            commit;
    logic            is_id;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        assign addr_arr[g]               = remote_addr[16*g +: 16];
        assign wdata_arr[g]              = remote_write_val[16*g +: 16];
        assign remote_read_val[16*g +: 16] = rv_q[g];
    end

    assign req    = remote_wren | remote_rden;
    assign live   = req[grant_q];
    assign is_id  = (addr_q == 16'hFFFF);
    assign commit = (state_q == S_ACK) && live;
    assign remote_ready = commit ? (NUM_CORES'(1) << grant_q) : '0;

    // Round-robin: first requester at or after last_grant+1, wrapping at NUM_CORES.
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            idx = {1'b0, last_q} + (GW+1)'(k);
            if (idx >= (GW+1)'(NUM_CORES)) idx = idx - (GW+1)'(NUM_CORES);
            if (!found && req[idx[GW-1:0]]) begin
                found = 1'b1;
                pick  = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    addr_d  = addr_arr[pick];
                    wdata_d = wdata_arr[pick];
                    wr_d    = remote_wren[pick];
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!live)                 state_d = S_IDLE;
                else if (WAIT_STATES > 0)  state_d = S_WAIT;
                else                       state_d = S_ACK;
            end
            S_WAIT: begin
                if (!live) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == WS_LAST) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                if (live) last_d = grant_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    // SRAM is never cleared; the read port tracks the latched address every cycle.
    always_ff @(posedge clk) begin
        if (commit && wr_q && !is_id) mem[addr_q[AW-1:0]] <= wdata_q;
        sram_q <= mem[addr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CORES; i++) rv_q[i] <= '0;
        end else if (commit && !wr_q) begin
            rv_q[grant_q] <= is_id ? {{(16-GW){1'b0}}, grant_q} : sram_q;
        end
    end
endmodule

// File: tb/tb_remote_responder.sv
// tb/tb_remote_responder.sv - randomized and directed bench for remote_responder against a transaction-level model
module tb_remote_responder;
    logic clk = 1'b0;
    logic rst0_n, rst3_n;
    logic [63:0] addr0, addr3, wd0, wd3, rv0, rv3;
    logic [3:0]  wren0, rden0, wren3, rden3, rdy0, rdy3;

    int checks = 0;
    int failures = 0;

    // Model state, index 0 = WAIT_STATES 0 instance, 1 = WAIT_STATES 3 instance.
    logic [15:0] m_mem   [2][4096];
    bit          m_known [2][4096];
    logic [15:0] m_rv    [2][4];
    bit          m_rv_ok [2][4];
    int          m_last  [2];

    bit          b_wr   [4];
    bit          b_rd   [4];
    logic [15:0] b_addr [4];
    logic [15:0] b_data [4];

    always #5 clk = ~clk;

    remote_responder #(.NUM_CORES(4), .MEM_SIZE(4096), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset_n(rst0_n), .remote_addr(addr0), .remote_wren(wren0),
        .remote_rden(rden0), .remote_write_val(wd0), .remote_ready(rdy0), .remote_read_val(rv0));

    remote_responder #(.NUM_CORES(4), .MEM_SIZE(4096), .WAIT_STATES(3)) u3 (
        .clk(clk), .reset_n(rst3_n), .remote_addr(addr3), .remote_wren(wren3),
        .remote_rden(rden3), .remote_write_val(wd3), .remote_ready(rdy3), .remote_read_val(rv3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int sel, input int c, input bit wr, input bit rd,
                           input logic [15:0] a, input logic [15:0] d);
        if (sel == 0) begin
            wren0[c] = wr; rden0[c] = rd; addr0[c*16 +: 16] = a; wd0[c*16 +: 16] = d;
        end else begin
            wren3[c] = wr; rden3[c] = rd; addr3[c*16 +: 16] = a; wd3[c*16 +: 16] = d;
        end
    endtask

    function automatic logic [3:0] get_ready(input int sel);
        return (sel == 0) ? rdy0 : rdy3;
    endfunction

    function automatic logic [15:0] get_rv(input int sel, input int c);
        return (sel == 0) ? rv0[c*16 +: 16] : rv3[c*16 +: 16];
    endfunction

    task automatic model_reset(input int sel);
        m_last[sel] = 3;
        for (int c = 0; c < 4; c++) begin
            m_rv[sel][c] = 16'h0000;
            m_rv_ok[sel][c] = 1'b1;
        end
    endtask

    function automatic int model_next(input int sel, input logic [3:0] pend);
        for (int k = 1; k <= 4; k++)
            if (pend[(m_last[sel] + k) % 4]) return (m_last[sel] + k) % 4;
        return -1;
    endfunction

    task automatic model_apply(input int sel, input int c);
        int a;
        a = int'(b_addr[c]) % 4096;
        if (b_wr[c]) begin
            if (b_addr[c] != 16'hFFFF) begin
                m_mem[sel][a] = b_data[c];
                m_known[sel][a] = 1'b1;
            end
        end else if (b_addr[c] == 16'hFFFF) begin
            m_rv[sel][c] = 16'(c);
            m_rv_ok[sel][c] = 1'b1;
        end else begin
            m_rv[sel][c] = m_mem[sel][a];
            m_rv_ok[sel][c] = m_known[sel][a];
        end
        m_last[sel] = c;
    endtask

    // Entered #1 after a rising edge; drives the batch and follows it to completion.
    task automatic run_batch(input int sel, input logic [3:0] mask);
        logic [3:0] pend, r;
        int ws, gap, drop, budget, g;
        bit first;
        ws = (sel == 0) ? 0 : 3;
        for (int c = 0; c < 4; c++)
            if (mask[c]) set_req(sel, c, b_wr[c], b_rd[c], b_addr[c], b_data[c]);
        pend = mask; gap = 0; drop = -1; budget = 200; first = 1'b1;
        while ((pend != 0 || drop >= 0) && budget > 0) begin
            @(posedge clk); #1;
            gap++; budget--;
            if (drop >= 0) begin
                if (m_rv_ok[sel][drop]) check("read_val", 32'(get_rv(sel, drop)), 32'(m_rv[sel][drop]));
                set_req(sel, drop, 1'b0, 1'b0, 16'h0, 16'h0);
                drop = -1;
            end
            r = get_ready(sel);
            if (r != 4'b0) begin
                g = model_next(sel, pend);
                check("grant", 32'(r), 32'(4'b1 << g));
                check("latency", gap, first ? 2 + ws : 3 + ws);
                if (m_rv_ok[sel][g]) check("rv_hold", 32'(get_rv(sel, g)), 32'(m_rv[sel][g]));
                model_apply(sel, g);
                pend[g] = 1'b0;
                drop = g; gap = 0; first = 1'b0;
            end
        end
        if (budget == 0) check("timeout", 32'(pend), 32'h0);
    endtask

    task automatic one(input int sel, input int c, input bit wr, input bit rd,
                       input logic [15:0] a, input logic [15:0] d);
        b_wr[c] = wr; b_rd[c] = rd; b_addr[c] = a; b_data[c] = d;
        run_batch(sel, 4'b1 << c);
    endtask

    initial begin
        logic [3:0] mask;
        int op;
        rst0_n = 1'b0; rst3_n = 1'b0;
        wren0 = '0; rden0 = '0; addr0 = '0; wd0 = '0;
        wren3 = '0; rden3 = '0; addr3 = '0; wd3 = '0;
        model_reset(0); model_reset(1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready0", 32'(rdy0), 32'h0);
        check("rst_ready3", 32'(rdy3), 32'h0);
        check("rst_rv0", 32'(rv0[31:0] | rv0[63:32]), 32'h0);
        rst0_n = 1'b1; rst3_n = 1'b1;

        for (int c = 0; c < 4; c++) begin
            b_wr[c] = 1'b0; b_rd[c] = 1'b1; b_addr[c] = 16'h4100 + 16'(c); b_data[c] = '0;
        end
        run_batch(0, 4'hF);

        one(0, 0, 1, 0, 16'h4010, 16'hBEEF);
        one(0, 0, 0, 1, 16'h4010, 16'h0);
        check("beef", 32'(get_rv(0, 0)), 32'hBEEF);

        one(0, 2, 0, 1, 16'hFFFF, 16'h0);
        check("id2", 32'(get_rv(0, 2)), 32'h0002);
        one(0, 2, 1, 0, 16'hFFFF, 16'h1234);
        one(0, 2, 0, 1, 16'hFFFF, 16'h0);
        check("id2_again", 32'(get_rv(0, 2)), 32'h0002);

        one(0, 1, 1, 1, 16'h4005, 16'hA5A5);
        one(0, 1, 0, 1, 16'h8005, 16'h0);
        check("mirror", 32'(get_rv(0, 1)), 32'hA5A5);

        for (int n = 0; n < 40; n++) begin
            mask = 4'($urandom_range(1, 15));
            for (int c = 0; c < 4; c++) begin
                op = int'($urandom_range(0, 2));
                b_wr[c] = (op != 0);
                b_rd[c] = (op != 1);
                if ($urandom_range(0, 9) == 9) b_addr[c] = 16'hFFFF;
                else b_addr[c] = {2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 12'($urandom_range(0, 7) * 3)};
                b_data[c] = 16'($urandom);
            end
            run_batch(0, mask);
        end

        one(1, 0, 1, 0, 16'h4020, 16'h0000);
        one(1, 0, 1, 0, 16'h4030, 16'h1357);
        one(1, 0, 0, 1, 16'h4030, 16'h0);
        check("ws3_rv", 32'(get_rv(1, 0)), 32'h1357);

        set_req(1, 0, 1'b1, 1'b0, 16'h4020, 16'h1234);
        repeat (2) @(posedge clk);
        #1;
        rst3_n = 1'b0;
        #1;
        check("midrst_ready", 32'(rdy3), 32'h0);
        check("midrst_rv", 32'(rv3[31:0] | rv3[63:32]), 32'h0);
        set_req(1, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        model_reset(1);
        repeat (2) @(posedge clk);
        #1;
        rst3_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            b_wr[c] = 1'b0; b_rd[c] = 1'b1; b_addr[c] = 16'h4020; b_data[c] = '0;
        end
        run_batch(1, 4'b0011);
        check("after_rst_c0", 32'(get_rv(1, 0)), 32'h0000);
        check("after_rst_c1", 32'(get_rv(1, 1)), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/remote_responder.md
Name: remote_responder

Overview:
- Target end of the core remote-access interface. Services remote reads and writes from NUM_CORES cores.
- Each core issues remote accesses for addresses with addr[15:14] != 2'b00.
- Accesses are arbitrated round-robin into one shared synchronous SRAM, plus one read-only ID register.
- Drives per-core remote_ready, which the core uses as its pipeline stall. Drives per-core remote_read_val, which the core consumes one cycle after completion.

Parameters:
- NUM_CORES, 4, number of initiator ports (1..16).
- MEM_SIZE, 4096, shared memory depth in 16-bit words (power of 2, max 16384).
- WAIT_STATES, 0, extra cycles inserted between ACCESS and ACK (0..15).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- remote_addr  in  16*NUM_CORES  per-core word address; core i at bits [16i+15:16i].
- remote_wren  in  NUM_CORES  per-core write request.
- remote_rden  in  NUM_CORES  per-core read request.
- remote_write_val  in  16*NUM_CORES  per-core write data.
- remote_ready  out  NUM_CORES  per-core completion strobe.
- remote_read_val  out  16*NUM_CORES  per-core registered read data.

Behaviour:
- Request rules:
  - Core i requests when wren[i] | rden[i].
  - The core holds addr, wren, rden and write_val stable until it sees ready[i]=1.
  - ready[i]=1 for exactly one cycle completes that access.
  - If wren and rden are both high, the access is a write.
- Address decode:
  - addr == 16'hFFFF: read returns the requesting core's index, zero-extended; a write is accepted and discarded.
  - All other addresses: SRAM index addr[$clog2(MEM_SIZE)-1:0]; higher bits are ignored, so the memory mirrors.
- FSM states: IDLE, ACCESS, WAIT, ACK.
  - IDLE: no ready asserted. If any core is requesting, pick the grant round-robin: first requester at or after (last_grant+1) mod NUM_CORES. Latch grant, addr, write_val and op, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: SRAM read address = latched addr. Go to WAIT if WAIT_STATES > 0, else go to ACK.
  - WAIT: counter runs WAIT_STATES cycles, then ACK.
  - ACK: ready[grant]=1, all other ready bits 0.
    - On the closing edge, a write stores write_val into the SRAM (the ID address is excluded).
    - On the closing edge, a read latches SRAM q, or the ID value, into read_val[grant].
    - Set last_grant = grant and return to IDLE.
- Latency: request visible in IDLE cycle T -> ready in cycle T+2+WAIT_STATES -> read_val valid from T+3+WAIT_STATES.
  - read_val[i] holds until core i's next completed read. Writes never alter read_val.
- Fairness:
  - A core whose request is still asserted on return to IDLE competes again under round-robin.
  - With all NUM_CORES requesting continuously, grants rotate 0,1,2,...
- Request withdrawn before ACK: protocol violation. The FSM aborts to IDLE at the next edge, no write occurs, ready stays 0 and last_grant is unchanged.
- Reset (reset_n low, asynchronous, any state including mid-access):
  - state=IDLE, all ready=0, all read_val=0, last_grant=NUM_CORES-1 (so core 0 has first priority), wait counter=0.
  - SRAM contents are not cleared.
  - A write in progress is dropped.
- Only one access is outstanding at any time. There is no pipelining across cores.

Test Plan:
- Write then read, core 0, WAIT_STATES=0: write 16'hBEEF to 16'h4010, then read 16'h4010 -> ready pulses 2 cycles after each request; read_val[0]=16'hBEEF one cycle after the read's ready.
- ID register: core 2 reads 16'hFFFF -> read_val[2]=16'h0002. A write of 16'h1234 to 16'hFFFF is followed by a re-read -> 16'h0002.
- Contention: cores 0..3 all assert reads of distinct addresses in the same cycle after reset -> ready order 0,1,2,3, one access every 3 cycles, no two ready bits high together.
- Wait states, WAIT_STATES=3: single read -> ready exactly 5 cycles after request; read_val changes only on the edge after ready.
- Reset mid-op: assert reset_n=0 during WAIT of a write to 16'h4020 (previously 16'h0000) -> all ready=0 and read_val=0 immediately. After release, reading 16'h4020 returns 16'h0000 and core 0 is granted first.
- Mirroring, MEM_SIZE=4096: write 16'hA5A5 to 16'h4005, then read 16'h8005 -> 16'hA5A5.
